// File: rtl/trap_sequencer.sv
// rtl/trap_sequencer.sv - machine trap entry/exit sequencer owning the M-mode trap CSRs
// Optional feature macro: VECTORED_MODE_EN (mtvec mode bit, vectored interrupt targets).
module trap_sequencer #(
    parameter int              XLEN      = 64,
    parameter logic [XLEN-1:0] RESET_VEC = '0
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            CS,
    input  logic [XLEN-1:0] CAUSE,
    input  logic [XLEN-1:0] EPC,
    input  logic [XLEN-1:0] TVAL,
    input  logic            MRET,
    input  logic            CSR_WE,
    input  logic [11:0]     CSR_ADDR,
    input  logic [XLEN-1:0] CSR_WDATA,
    output logic [XLEN-1:0] CSR_RDATA,
    output logic [1:0]      PRIV,
    output logic            TRAP_ACK,
    output logic            FLUSH,
    output logic            REDIRECT,
    output logic [XLEN-1:0] REDIRECT_PC,
    output logic            BUSY
);

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] ADDR_MTVAL   = 12'h343;
    localparam logic [1:0]  PRIV_M       = 2'd3;

`ifdef VECTORED_MODE_EN
    localparam logic [XLEN-1:0] MTVEC_MASK = ~XLEN'(2);
`else
    localparam logic [XLEN-1:0] MTVEC_MASK = ~XLEN'(3);
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_SAVE,
        S_RET,
        S_JUMP
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      priv_q, priv_d;
    logic [1:0]      mpp_q, mpp_d;
    logic            mie_q, mie_d;
    logic            mpie_q, mpie_d;
    logic [XLEN-1:0] mtvec_q, mtvec_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d;
    logic [XLEN-1:0] mtval_q, mtval_d;
    logic [XLEN-1:0] cause_q, cause_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic [XLEN-1:0] tval_q, tval_d;
    logic [XLEN-1:0] target_q, target_d;

    logic            take_trap;
    logic [XLEN-1:0] trap_base;
    logic [XLEN-1:0] trap_target;

    // Interrupts are gated by MIE; synchronous exceptions never are.
    assign take_trap = CS && (!CAUSE[XLEN-1] || mie_q);
    assign trap_base = {mtvec_q[XLEN-1:2], 2'b00};

`ifdef VECTORED_MODE_EN
    assign trap_target = (mtvec_q[0] && cause_q[XLEN-1])
                       ? trap_base + XLEN'({cause_q[5:0], 2'b00})
                       : trap_base;
`else
    assign trap_target = trap_base;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= S_IDLE;
            priv_q   <= PRIV_M;
            mpp_q    <= 2'd0;
            mie_q    <= 1'b0;
            mpie_q   <= 1'b0;
            mtvec_q  <= RESET_VEC;
            mepc_q   <= '0;
            mcause_q <= '0;
            mtval_q  <= '0;
            cause_q  <= '0;
            epc_q    <= '0;
            tval_q   <= '0;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            priv_q   <= priv_d;
            mpp_q    <= mpp_d;
            mie_q    <= mie_d;
            mpie_q   <= mpie_d;
            mtvec_q  <= mtvec_d;
            mepc_q   <= mepc_d;
            mcause_q <= mcause_d;
            mtval_q  <= mtval_d;
            cause_q  <= cause_d;
            epc_q    <= epc_d;
            tval_q   <= tval_d;
            target_q <= target_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        priv_d   = priv_q;
        mpp_d    = mpp_q;
        mie_d    = mie_q;
        mpie_d   = mpie_q;
        mtvec_d  = mtvec_q;
        mepc_d   = mepc_q;
        mcause_d = mcause_q;
        mtval_d  = mtval_q;
        cause_d  = cause_q;
        epc_d    = epc_q;
        tval_d   = tval_q;
        target_d = target_q;

        case (state_q)
            S_IDLE: begin
                if (CSR_WE) begin
                    case (CSR_ADDR)
                        ADDR_MSTATUS: begin
                            mie_d  = CSR_WDATA[3];
                            mpie_d = CSR_WDATA[7];
                            mpp_d  = CSR_WDATA[12:11];
                        end
                        ADDR_MTVEC:  mtvec_d  = CSR_WDATA & MTVEC_MASK;
                        ADDR_MEPC:   mepc_d   = {CSR_WDATA[XLEN-1:2], 2'b00};
                        ADDR_MCAUSE: mcause_d = CSR_WDATA;
                        ADDR_MTVAL:  mtval_d  = CSR_WDATA;
                        default: ;
                    endcase
                end
                if (take_trap) begin
                    cause_d = CAUSE;
                    epc_d   = EPC;
                    tval_d  = TVAL;
                    state_d = S_SAVE;
                end else if (MRET) begin
                    state_d = S_RET;
                end
            end
            S_SAVE: begin
                mepc_d   = {epc_q[XLEN-1:2], 2'b00};
                mcause_d = cause_q;
                mtval_d  = cause_q[XLEN-1] ? '0 : tval_q;
                mpie_d   = mie_q;
                mie_d    = 1'b0;
                mpp_d    = priv_q;
                priv_d   = PRIV_M;
                target_d = trap_target;
                state_d  = S_JUMP;
            end
            S_RET: begin
                priv_d   = mpp_q;
                mie_d    = mpie_q;
                mpie_d   = 1'b1;
                mpp_d    = 2'd0;
                target_d = mepc_q;
                state_d  = S_JUMP;
            end
            S_JUMP: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        CSR_RDATA = '0;
        case (CSR_ADDR)
            ADDR_MSTATUS: begin
                CSR_RDATA[3]     = mie_q;
                CSR_RDATA[7]     = mpie_q;
                CSR_RDATA[12:11] = mpp_q;
            end
            ADDR_MTVEC:  CSR_RDATA = mtvec_q;
            ADDR_MEPC:   CSR_RDATA = mepc_q;
            ADDR_MCAUSE: CSR_RDATA = mcause_q;
            ADDR_MTVAL:  CSR_RDATA = mtval_q;
            default:     CSR_RDATA = '0;
        endcase
    end

    assign PRIV        = priv_q;
    assign BUSY        = (state_q != S_IDLE);
    assign FLUSH       = (state_q != S_IDLE);
    assign TRAP_ACK    = (state_q == S_SAVE);
    assign REDIRECT    = (state_q == S_JUMP);
    assign REDIRECT_PC = (state_q == S_JUMP) ? target_q : '0;

endmodule

// File: tb/tb_trap_sequencer.sv
// tb/tb_trap_sequencer.sv - directed self-checking bench for trap_sequencer with an architectural model
module tb_trap_sequencer;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        CS = 1'b0;
    logic [63:0] CAUSE = '0;
    logic [63:0] EPC = '0;
    logic [63:0] TVAL = '0;
    logic        MRET = 1'b0;
    logic        CSR_WE = 1'b0;
    logic [11:0] CSR_ADDR = '0;
    logic [63:0] CSR_WDATA = '0;
    logic [63:0] CSR_RDATA;
    logic [1:0]  PRIV;
    logic        TRAP_ACK;
    logic        FLUSH;
    logic        REDIRECT;
    logic [63:0] REDIRECT_PC;
    logic        BUSY;

    int total = 0;
    int bad   = 0;

    localparam logic [63:0] INTR7 = 64'h8000_0000_0000_0007;

    trap_sequencer #(.XLEN(64), .RESET_VEC(64'h0)) dut (
        .CLK(CLK), .RST_N(RST_N), .CS(CS), .CAUSE(CAUSE), .EPC(EPC), .TVAL(TVAL),
        .MRET(MRET), .CSR_WE(CSR_WE), .CSR_ADDR(CSR_ADDR), .CSR_WDATA(CSR_WDATA),
        .CSR_RDATA(CSR_RDATA), .PRIV(PRIV), .TRAP_ACK(TRAP_ACK), .FLUSH(FLUSH),
        .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC), .BUSY(BUSY)
    );

    initial forever #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: architectural CSR state updated at acceptance, plus a queue of per-cycle outputs.
    typedef struct {
        bit          busy;
        bit          ack;
        bit          redir;
        logic [63:0] pc;
    } exp_t;

    exp_t        q[$];
    exp_t        cur;
    logic [1:0]  m_priv, m_mpp;
    bit          m_mie, m_mpie;
    logic [63:0] m_mtvec, m_mepc, m_mcause, m_mtval;

    function automatic exp_t mk(input bit b, input bit a, input bit r, input logic [63:0] pc);
        exp_t e;
        e.busy = b; e.ack = a; e.redir = r; e.pc = pc;
        return e;
    endfunction

    function automatic logic [63:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return (64'(m_mpp) << 11) | (64'(m_mpie) << 7) | (64'(m_mie) << 3);
            12'h305: return m_mtvec;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h343: return m_mtval;
            default: return 64'h0;
        endcase
    endfunction

    task automatic m_reset();
        q.delete();
        cur = mk(0, 0, 0, 0);
        m_priv = 3; m_mpp = 0; m_mie = 0; m_mpie = 0;
        m_mtvec = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0;
    endtask

    task automatic m_step();
        bit          take;
        logic [63:0] pc;
        if (!cur.busy) begin
            take = CS && (!CAUSE[63] || m_mie);
            if (CSR_WE) begin
                case (CSR_ADDR)
                    12'h300: begin
                        m_mie  = CSR_WDATA[3];
                        m_mpie = CSR_WDATA[7];
                        m_mpp  = CSR_WDATA[12:11];
                    end
`ifdef VECTORED_MODE_EN
                    12'h305: m_mtvec = CSR_WDATA & ~64'h2;
`else
                    12'h305: m_mtvec = CSR_WDATA & ~64'h3;
`endif
                    12'h341: m_mepc   = CSR_WDATA & ~64'h3;
                    12'h342: m_mcause = CSR_WDATA;
                    12'h343: m_mtval  = CSR_WDATA;
                    default: ;
                endcase
            end
            if (take) begin
                m_mepc   = EPC & ~64'h3;
                m_mcause = CAUSE;
                m_mtval  = CAUSE[63] ? 64'h0 : TVAL;
                m_mpie   = m_mie;
                m_mie    = 0;
                m_mpp    = m_priv;
                m_priv   = 3;
                pc       = m_mtvec & ~64'h3;
`ifdef VECTORED_MODE_EN
                if (m_mtvec[0] && CAUSE[63]) pc = pc + 4 * (CAUSE & 64'h3F);
`endif
                q.push_back(mk(1, 1, 0, 0));
                q.push_back(mk(1, 0, 1, pc));
            end else if (MRET) begin
                pc     = m_mepc;
                m_priv = m_mpp;
                m_mie  = m_mpie;
                m_mpie = 1;
                m_mpp  = 0;
                q.push_back(mk(1, 0, 0, 0));
                q.push_back(mk(1, 0, 1, pc));
            end
        end
        cur = (q.size() > 0) ? q.pop_front() : mk(0, 0, 0, 0);
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge CLK or negedge RST_N);
            if (!RST_N) m_reset();
            else        m_step();
        end
    end

    initial begin
        forever begin
            @(negedge CLK);
            chk("busy", BUSY, cur.busy);
            chk("flush", FLUSH, cur.busy);
            chk("trap_ack", TRAP_ACK, cur.ack);
            chk("redirect", REDIRECT, cur.redir);
            chk("redirect_pc", REDIRECT_PC, cur.redir ? cur.pc : 64'h0);
            if (!cur.busy) begin
                chk("priv", PRIV, m_priv);
                chk("csr_rdata", CSR_RDATA, m_read(CSR_ADDR));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic rd(input string name, input logic [11:0] a, input logic [63:0] exp);
        CSR_ADDR = a;
        #1;
        chk(name, CSR_RDATA, exp);
    endtask

    task automatic csr_write(input logic [11:0] a, input logic [63:0] d);
        CSR_WE = 1; CSR_ADDR = a; CSR_WDATA = d;
        tick();
        CSR_WE = 0;
    endtask

    task automatic do_trap(input logic [63:0] c, input logic [63:0] e, input logic [63:0] t);
        CS = 1; CAUSE = c; EPC = e; TVAL = t;
        tick();
        CS = 0;
        repeat (3) tick();
    endtask

    task automatic do_mret();
        MRET = 1;
        tick();
        MRET = 0;
        repeat (3) tick();
    endtask

    task automatic trap_pc(input string name, input logic [63:0] c, input logic [63:0] exp_pc);
        CS = 1; CAUSE = c; EPC = 64'h9000; TVAL = 64'h1;
        tick();
        CS = 0;
        tick();
        @(negedge CLK);
        chk({name, "_redir"}, REDIRECT, 1);
        chk({name, "_pc"}, REDIRECT_PC, exp_pc);
        repeat (2) tick();
    endtask

    initial begin
        int acks;
        repeat (2) tick();
        RST_N = 1;
        tick();
        chk("reset_priv", PRIV, 3);
        chk("reset_busy", BUSY, 0);
        chk("reset_redirect", REDIRECT, 0);
        rd("reset_mtvec", 12'h305, 64'h0);
        rd("reset_mstatus", 12'h300, 64'h0);

        // Exception entry with literal latency and CSR values
        csr_write(12'h305, 64'h8000_0000);
        CS = 1; CAUSE = 64'd2; EPC = 64'h1006; TVAL = 64'h13;
        tick();
        CS = 0;
        @(negedge CLK);
        chk("t1_ack", TRAP_ACK, 1);
        chk("t1_no_redirect_yet", REDIRECT, 0);
        tick();
        @(negedge CLK);
        chk("t1_redirect", REDIRECT, 1);
        chk("t1_pc", REDIRECT_PC, 64'h8000_0000);
        tick();
        rd("t1_mepc", 12'h341, 64'h1004);
        rd("t1_mtval", 12'h343, 64'h13);
        rd("t1_mcause", 12'h342, 64'd2);
        chk("t1_priv", PRIV, 3);

        // Masked interrupt dropped, then taken with MIE=1
        csr_write(12'h300, 64'h0);
        CS = 1; CAUSE = INTR7; EPC = 64'h2000; TVAL = 64'h55;
        repeat (2) begin
            tick();
            @(negedge CLK);
            chk("t2_masked_busy", BUSY, 0);
            chk("t2_masked_ack", TRAP_ACK, 0);
        end
        CS = 0;
        tick();
        csr_write(12'h300, 64'h8);
        do_trap(INTR7, 64'h2000, 64'h55);
        rd("t2_mtval", 12'h343, 64'h0);
        rd("t2_mstatus", 12'h300, 64'h1880);
        rd("t2_mcause", 12'h342, INTR7);

        // MRET to U, trap from U, MRET back
        csr_write(12'h300, 64'h80);
        do_mret();
        chk("t3_priv_u", PRIV, 0);
        rd("t3_mstatus_after_mret", 12'h300, 64'h88);
        do_trap(64'd8, 64'h3000, 64'h0);
        rd("t3_mstatus_in_trap", 12'h300, 64'h80);
        chk("t3_priv_m", PRIV, 3);
        MRET = 1;
        tick();
        MRET = 0;
        tick();
        @(negedge CLK);
        chk("t3_mret_redirect", REDIRECT, 1);
        chk("t3_mret_pc", REDIRECT_PC, 64'h3000);
        tick();
        chk("t3_priv_back", PRIV, 0);
        rd("t3_mstatus_back", 12'h300, 64'h88);

        // CS beats MRET; CS held 3 cycles gives one ack
        CS = 1; MRET = 1; CAUSE = 64'd2; EPC = 64'h4000; TVAL = 64'h7;
        acks = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            MRET = 0;
            @(negedge CLK);
            acks += int'(TRAP_ACK);
        end
        CS = 0;
        repeat (2) begin
            tick();
            @(negedge CLK);
            acks += int'(TRAP_ACK);
        end
        chk("t4_ack_count", 64'(acks), 64'd1);
        chk("t4_priv", PRIV, 3);
        rd("t4_mepc", 12'h341, 64'h4000);

        // CSR write during SAVE ignored; unmapped address
        CS = 1; CAUSE = 64'd2; EPC = 64'h5000; TVAL = 64'h0;
        tick();
        CS = 0;
        CSR_WE = 1; CSR_ADDR = 12'h341; CSR_WDATA = 64'hDEAD0;
        tick();
        CSR_WE = 0;
        repeat (2) tick();
        rd("t5_mepc", 12'h341, 64'h5000);
        csr_write(12'h7C0, 64'hFFFF);
        rd("t5_unmapped", 12'h7C0, 64'h0);

        // Trap target selection
        csr_write(12'h300, 64'h8);
        csr_write(12'h305, 64'h8000_0003);
`ifdef VECTORED_MODE_EN
        rd("t6_mtvec", 12'h305, 64'h8000_0001);
        trap_pc("t6_vec_intr", INTR7, 64'h8000_001C);
        trap_pc("t6_vec_exc", 64'd2, 64'h8000_0000);
`else
        rd("t6_mtvec", 12'h305, 64'h8000_0000);
        trap_pc("t6_direct_intr", INTR7, 64'h8000_0000);
`endif

        // Reset during JUMP of an MRET that dropped to U
        csr_write(12'h300, 64'h0);
        MRET = 1;
        tick();
        MRET = 0;
        tick();
        RST_N = 0;
        @(negedge CLK);
        chk("t6_rst_redirect", REDIRECT, 0);
        chk("t6_rst_priv", PRIV, 3);
        chk("t6_rst_busy", BUSY, 0);
        tick();
        RST_N = 1;
        repeat (2) tick();
        rd("t6_rst_mtvec", 12'h305, 64'h0);
        chk("t6_rst_priv_after", PRIV, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
